// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and helpers for the forwarding / hazard scoreboard.
// Entry fields are sized for the largest supported configuration; narrower ports zero-extend.
package fwd_pkg;

  localparam int unsigned MaxRegAddrW = 8;
  localparam int unsigned MaxLatW     = 4;

  localparam int unsigned FWD_SEL_RF = 0;

  typedef struct packed {
    logic                   valid;
    logic [MaxRegAddrW-1:0] rd;
    logic [MaxLatW-1:0]     rem;
  } fwd_entry_t;

  function automatic int unsigned fwd_sel_stage(int unsigned k);
    return k + 1;
  endfunction

  function automatic logic [MaxLatW-1:0] sat_dec(logic [MaxLatW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Decode-side bundle: ID instruction fields in, stall and bypass selects out.
interface fwd_hazard_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LAT_W      = 2
);
  localparam int unsigned SEL_W = $clog2(FWD_STAGES + 1);

  logic                          id_valid;
  logic                          id_flush;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic [REG_ADDR_W-1:0]         id_rd;
  logic                          id_reg_write;
  logic [LAT_W-1:0]              id_lat;
  logic                          stall;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;

  modport master (
    output id_valid, id_flush, id_rs, id_rs_used, id_rd, id_reg_write, id_lat,
    input  stall, fwd_sel
  );

  modport slave (
    input  id_valid, id_flush, id_rs, id_rs_used, id_rd, id_reg_write, id_lat,
    output stall, fwd_sel
  );

endinterface

// File: rtl/fwd_hazard_scoreboard_src_match.sv
// Priority match of one source operand against the in-flight writer entries.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned FWD_STAGES = 2,
  localparam int unsigned SEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  fwd_entry_t [FWD_STAGES-1:0] entries_i,
  input  logic [REG_ADDR_W-1:0]       rs_i,
  input  logic                        rs_used_i,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        src_stall_o
);

  logic [MaxRegAddrW-1:0] rs_ext;
  logic                   found;

  assign rs_ext = MaxRegAddrW'(rs_i);

  // Youngest match decides alone: an unready youngest stalls even if an older copy is ready.
  always_comb begin
    sel_o       = SEL_W'(FWD_SEL_RF);
    src_stall_o = 1'b0;
    found       = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (!found && entries_i[k].valid && (entries_i[k].rd == rs_ext) && rs_used_i &&
          (rs_ext != '0)) begin
        found = 1'b1;
        if (entries_i[k].rem == '0) begin
          sel_o = SEL_W'(fwd_sel_stage(k));
        end else begin
          src_stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and stall controller: shift scoreboard of in-flight writers, per-source
// bypass selects, load-use stall and a saturating stalled-cycle counter.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LAT_W      = 2,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_cnt_clr,
  output logic [CNT_W-1:0]      stall_cnt,
  fwd_hazard_scoreboard_if.slave id_bus
);

  localparam logic [MaxLatW-1:0] LatMax = MaxLatW'(FWD_STAGES - 1);

  fwd_entry_t [FWD_STAGES-1:0]     ent_q, ent_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_SRC-1:0][SEL_W-1:0]   sel;
  logic [NUM_SRC-1:0]              src_stall;
  logic [LAT_W-1:0]                lat_raw;
  logic [MaxLatW-1:0]              lat_ext;
  logic                            stall;
  logic                            issue;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_STAGES (FWD_STAGES)
    ) u_match (
      .entries_i   (ent_q),
      .rs_i        (id_bus.id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used_i   (id_bus.id_rs_used[i]),
      .sel_o       (sel[i]),
      .src_stall_o (src_stall[i])
    );
  end

  assign stall          = id_bus.id_valid & ~id_bus.id_flush & (|src_stall);
  assign issue          = id_bus.id_valid & ~id_bus.id_flush & ~stall;
  assign id_bus.stall   = stall;
  assign id_bus.fwd_sel = sel;
  assign stall_cnt      = cnt_q;
  assign lat_raw        = id_bus.id_lat;
  assign lat_ext        = MaxLatW'(lat_raw);

  always_comb begin
    ent_d          = ent_q;
    ent_d[0].valid = issue & id_bus.id_reg_write & (id_bus.id_rd != '0);
    ent_d[0].rd    = MaxRegAddrW'(id_bus.id_rd);
    // Clamp so every writer is ready before it drops into the regfile.
    ent_d[0].rem   = (lat_ext > LatMax) ? LatMax : lat_ext;
    for (int unsigned k = 1; k < FWD_STAGES; k++) begin
      ent_d[k].valid = ent_q[k-1].valid;
      ent_d[k].rd    = ent_q[k-1].rd;
      ent_d[k].rem   = sat_dec(ent_q[k-1].rem);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_cnt_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: forwarding, load-use stall, exclusions, counter.
module tb_fwd_hazard_scoreboard;

  localparam int unsigned RegAddrW  = 4;
  localparam int unsigned NumSrc    = 2;
  localparam int unsigned FwdStages = 2;
  localparam int unsigned LatW      = 2;
  localparam int unsigned CntW      = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall_cnt_clr;
  logic [CntW-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  fwd_hazard_scoreboard_if #(
    .REG_ADDR_W (RegAddrW),
    .NUM_SRC    (NumSrc),
    .FWD_STAGES (FwdStages),
    .LAT_W      (LatW)
  ) bus ();

  fwd_hazard_scoreboard #(
    .REG_ADDR_W (RegAddrW),
    .NUM_SRC    (NumSrc),
    .FWD_STAGES (FwdStages),
    .LAT_W      (LatW),
    .CNT_W      (CntW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt),
    .id_bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl, input logic [3:0] rs0,
                       input logic [3:0] rs1, input logic [1:0] used, input logic [3:0] rd,
                       input logic wr, input logic [1:0] lat);
    bus.id_valid     = v;
    bus.id_flush     = fl;
    bus.id_rs        = {rs1, rs0};
    bus.id_rs_used   = used;
    bus.id_rd        = rd;
    bus.id_reg_write = wr;
    bus.id_lat       = lat;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    stall_cnt_clr = 1'b0;
    rst_n         = 1'b0;
    drive(1'b1, 1'b0, 4'd3, 4'd3, 2'b11, 4'd0, 1'b0, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_sel", 32'(bus.fwd_sel), 32'h0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);

    // ALU back-to-back, then one bubble later
    drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 2'd0);
    chk("alu_issue_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, 4'd5, 4'd0, 2'b01, 4'd0, 1'b0, 2'd0);
    chk("alu_b2b_sel", 32'(bus.fwd_sel), 32'h1);
    chk("alu_b2b_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, 4'd5, 4'd0, 2'b01, 4'd0, 1'b0, 2'd0);
    chk("alu_gap_sel", 32'(bus.fwd_sel), 32'h2);
    tick();
    chk("alu_retired_sel", 32'(bus.fwd_sel), 32'h0);
    tick();

    // Load-use on source 1
    drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 2'd1);
    tick();
    drive(1'b1, 1'b0, 4'd0, 4'd7, 2'b10, 4'd0, 1'b0, 2'd0);
    chk("load_use_stall", 32'(bus.stall), 32'd1);
    chk("load_use_sel", 32'(bus.fwd_sel), 32'h0);
    tick();
    chk("load_after_stall", 32'(bus.stall), 32'd0);
    chk("load_after_sel", 32'(bus.fwd_sel), 32'h8);
    chk("load_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // Two writers of r4: youngest wins on both sources
    drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 2'd0);
    tick();
    tick();
    drive(1'b1, 1'b0, 4'd4, 4'd4, 2'b11, 4'd0, 1'b0, 2'd0);
    chk("double_hit_sel", 32'(bus.fwd_sel), 32'h5);
    chk("double_hit_stall", 32'(bus.stall), 32'd0);
    tick();

    // Writer to r0 is never tracked
    drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 2'd1);
    tick();
    drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b11, 4'd0, 1'b0, 2'd0);
    chk("r0_sel", 32'(bus.fwd_sel), 32'h0);
    chk("r0_stall", 32'(bus.stall), 32'd0);
    tick();

    // Unused operand does not stall
    drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd9, 1'b1, 2'd1);
    tick();
    drive(1'b1, 1'b0, 4'd9, 4'd9, 2'b00, 4'd0, 1'b0, 2'd0);
    chk("unused_stall", 32'(bus.stall), 32'd0);
    chk("unused_sel", 32'(bus.fwd_sel), 32'h0);
    tick();

    // Flush over a hazard: no stall, and the flushed writer leaves a bubble
    drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd10, 1'b1, 2'd1);
    tick();
    drive(1'b1, 1'b1, 4'd10, 4'd0, 2'b01, 4'd10, 1'b1, 2'd1);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, 4'd10, 4'd0, 2'b01, 4'd0, 1'b0, 2'd0);
    chk("flush_bubble_stall", 32'(bus.stall), 32'd0);
    chk("flush_bubble_sel", 32'(bus.fwd_sel), 32'h2);
    chk("flush_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // Counter clear, then alternate stall/issue until it saturates
    drive(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 2'd0);
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    chk("clr_cnt", 32'(stall_cnt), 32'd0);
    drive(1'b1, 1'b0, 4'd0, 4'd7, 2'b10, 4'd7, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_partial_cnt", 32'(stall_cnt), 32'd2);
    for (int i = 0; i < 36; i++) tick();
    chk("sat_cnt", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 3 && !bus.stall; i++) tick();
    chk("sat_clr_stall", 32'(bus.stall), 32'd1);
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    chk("sat_clr_cnt", 32'(stall_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
